// File: rtl/uart_port_bridge_pkg.sv
// Shared command codes, response bytes and state encodings for the UART port bridge.
package uart_port_bridge_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h2E;
   localparam logic [7:0] RSP_ERR = 8'h3F;

   // 16x oversampling: tick index of mid-start re-check and of each bit boundary
   localparam logic [3:0] OSR_MID  = 4'd7;
   localparam logic [3:0] OSR_LAST = 4'd15;

   typedef enum logic [2:0] {
      IDLE,
      W_ADDR,
      W_DATA,
      W_STB,
      R_ADDR,
      R_WAIT,
      R_STB,
      SEND
   } bridge_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/bridge_serial_rx.sv
// 8N1 receiver: two-flop synchroniser, 16x oversampled start/data/stop sampling,
// single-cycle byte_valid_o on a correctly framed byte.
module bridge_serial_rx
   import uart_port_bridge_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_i,
   input  logic       rx_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o
);

   logic       rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       valid_q, valid_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         valid_q   <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         if (tick_i) rx_prev_q <= rx_sync_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      if (tick_i) begin
         case (state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_sync_q) begin
                  state_d = RX_START;
                  cnt_d   = '0;
               end
            end
            RX_START: begin
               // A line that is high again mid-start was only a glitch
               if (cnt_q == OSR_MID) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  state_d = rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            RX_DATA: begin
               if (cnt_q == OSR_LAST) begin
                  cnt_d   = '0;
                  shift_d = {rx_sync_q, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = RX_STOP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            RX_STOP: begin
               if (cnt_q == OSR_LAST) begin
                  valid_d = rx_sync_q;
                  state_d = RX_IDLE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   assign byte_valid_o = valid_q;
   assign byte_o       = shift_q;

endmodule

// File: rtl/uart_port_bridge.sv
// UART-to-port-bus initiator: 'W' addr data writes a port, 'R' addr reads one back over tx.
// Optional inter-byte timeout enabled by defining UART_PORT_BRIDGE_TIMEOUT_EN.
module uart_port_bridge
   import uart_port_bridge_pkg::*;
#(
   parameter int BAUD_DIV      = 26,
   parameter int TIMEOUT_TICKS = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] port_id,
   output logic [7:0] out_port,
   output logic       write_strobe,
   output logic       read_strobe,
   input  logic [7:0] in_port,
   output logic       busy
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [BW-1:0] baud_cnt_q;
   logic          tick;
   logic          byte_valid;
   logic [7:0]    rx_byte;

   bridge_state_e state_q, state_d;
   logic [7:0]    port_id_q, port_id_d;
   logic [7:0]    out_port_q, out_port_d;
   logic [7:0]    rsp_q, rsp_d;
   logic          tx_load;
   logic          timed_out;

   logic          tx_busy_q;
   logic [9:0]    tx_shift_q;
   logic [3:0]    tx_tick_q;
   logic [3:0]    tx_bit_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               baud_cnt_q <= '0;
      else if (baud_cnt_q == BW'(BAUD_DIV-1)) baud_cnt_q <= '0;
      else                                    baud_cnt_q <= baud_cnt_q + 1'b1;
   end
   assign tick = (baud_cnt_q == BW'(BAUD_DIV-1));

   bridge_serial_rx u_rx (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick),
      .rx_i         (rx),
      .byte_valid_o (byte_valid),
      .byte_o       (rx_byte)
   );

`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   logic [TW-1:0] to_cnt_q;
   logic          waiting;

   assign waiting   = (state_q == W_ADDR) || (state_q == W_DATA) || (state_q == R_ADDR);
   assign timed_out = waiting && (to_cnt_q == TW'(TIMEOUT_TICKS));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       to_cnt_q <= '0;
      else if (!waiting || byte_valid) to_cnt_q <= '0;
      else if (tick && !timed_out)     to_cnt_q <= to_cnt_q + 1'b1;
   end
`else
   // Never fires; the comparison only keeps the parameter referenced.
   assign timed_out = (TIMEOUT_TICKS < 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         port_id_q  <= '0;
         out_port_q <= '0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         port_id_q  <= port_id_d;
         out_port_q <= out_port_d;
         rsp_q      <= rsp_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      port_id_d  = port_id_q;
      out_port_d = out_port_q;
      rsp_d      = rsp_q;
      tx_load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (byte_valid) begin
               if (rx_byte == CMD_WR)      state_d = W_ADDR;
               else if (rx_byte == CMD_RD) state_d = R_ADDR;
               else begin
                  rsp_d   = RSP_ERR;
                  state_d = SEND;
               end
            end
         end
         W_ADDR: if (byte_valid) begin port_id_d  = rx_byte; state_d = W_DATA; end
         W_DATA: if (byte_valid) begin out_port_d = rx_byte; state_d = W_STB;  end
         W_STB: begin
            rsp_d   = RSP_ACK;
            state_d = SEND;
         end
         R_ADDR: if (byte_valid) begin port_id_d = rx_byte; state_d = R_WAIT; end
         R_WAIT: state_d = R_STB;
         R_STB: begin
            rsp_d   = in_port;
            state_d = SEND;
         end
         SEND: begin
            if (!tx_busy_q) begin
               tx_load = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A byte arriving on the same cycle as the timeout still counts
      if (timed_out && !byte_valid) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_busy_q  <= 1'b0;
         tx_shift_q <= '1;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
      end else if (tx_load) begin
         tx_busy_q  <= 1'b1;
         tx_shift_q <= {1'b1, rsp_q, 1'b0};
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
      end else if (tx_busy_q && tick) begin
         if (tx_tick_q == OSR_LAST) begin
            tx_tick_q <= '0;
            if (tx_bit_q == 4'd9) begin
               tx_busy_q <= 1'b0;
            end else begin
               tx_shift_q <= {1'b1, tx_shift_q[9:1]};
               tx_bit_q   <= tx_bit_q + 4'd1;
            end
         end else begin
            tx_tick_q <= tx_tick_q + 4'd1;
         end
      end
   end

   assign tx           = !tx_busy_q || tx_shift_q[0];
   assign port_id      = port_id_q;
   assign out_port     = out_port_q;
   assign write_strobe = (state_q == W_STB);
   assign read_strobe  = (state_q == R_STB);
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_port_bridge.sv
// Directed bench for uart_port_bridge: table of command records plus hand sequences
// for glitch rejection, inter-byte wait/timeout and asynchronous reset mid-response.
module tb_uart_port_bridge;

   localparam int BAUD_DIV = 26;
   localparam int BIT      = BAUD_DIV * 16;
   localparam int HALF     = BIT / 2;
   localparam int FRAME    = BIT * 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       tx;
   logic [7:0] port_id, out_port, in_port;
   logic       write_strobe, read_strobe, busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_port_bridge #(.BAUD_DIV(BAUD_DIV), .TIMEOUT_TICKS(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .tx           (tx),
      .port_id      (port_id),
      .out_port     (out_port),
      .write_strobe (write_strobe),
      .read_strobe  (read_strobe),
      .in_port      (in_port),
      .busy         (busy)
   );

   // Responder: registers read data one cycle after port_id
   logic [7:0] mem [256];
   always @(posedge clk) in_port <= mem[port_id];

   // Strobe monitor
   int         wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
   logic [7:0] wr_pid = '0, wr_dat = '0, rd_pid = '0;
   always @(negedge clk) begin
      if (write_strobe) begin wr_cnt++; wr_pid = port_id; wr_dat = out_port; end
      if (read_strobe)  begin rd_cnt++; rd_pid = port_id; end
      if (write_strobe && read_strobe) both_cnt++;
   end

   // tx decoder and scoreboard queues
   logic [7:0] tx_q  [$];
   logic [7:0] exp_q [$];
   logic [9:0] mon_frame = '0;
   logic [9:0] mon_cap;
   always begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
         repeat (HALF) @(negedge clk);
         mon_cap[0] = tx;
         for (int i = 1; i < 10; i++) begin
            repeat (BIT) @(negedge clk);
            mon_cap[i] = tx;
         end
         mon_frame = mon_cap;
         tx_q.push_back(mon_cap[8:1]);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      if (!stop) repeat (BIT) @(negedge clk);
   endtask

   task automatic wait_rsp(input string name, input logic [7:0] exp);
      int n = 0;
      exp_q.push_back(exp);
      while (tx_q.size() == 0 && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if (tx_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no response byte, expected %0h", name, exp);
         void'(exp_q.pop_front());
      end else begin
         logic [7:0] got, want;
         got  = tx_q.pop_front();
         want = exp_q.pop_front();
         check(name, {24'h0, got}, {24'h0, want});
      end
   endtask

   typedef struct {
      int               n;
      logic [2:0][7:0]  b;
      logic             bad_stop0;
      logic             ewr;
      logic             erd;
      logic [7:0]       epid;
      logic [7:0]       edat;
      logic [7:0]       ersp;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int bad, wr0, rd0, n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h01] = 8'h3C;
      mem[8'h00] = 8'h99;
      mem[8'h20] = 8'h11;

      //         n  bytes (b[0] sent first)       bad ewr  erd  pid    dat    rsp
      vecs[0] = '{3, {8'hA5, 8'h10, 8'h57}, 1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 8'h2E};
      vecs[1] = '{2, {8'h00, 8'h01, 8'h52}, 1'b0, 1'b0, 1'b1, 8'h01, 8'hA5, 8'h3C};
      vecs[2] = '{1, {8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 8'h01, 8'hA5, 8'h3F};
      vecs[3] = '{3, {8'h00, 8'h52, 8'h57}, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h99};

      rx  = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;

      check("rst_tx", tx, 1);
      check("rst_port_id", port_id, 0);
      check("rst_out_port", out_port, 0);
      check("rst_busy", busy, 0);
      check("rst_strobes", {write_strobe, read_strobe}, 0);

      bad = 0;
      for (int c = 0; c < 20 * BIT; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || port_id !== 8'h00 || out_port !== 8'h00 ||
             write_strobe !== 1'b0 || read_strobe !== 1'b0) bad++;
      end
      check("idle_20_bits", bad, 0);

      for (int i = 0; i < 4; i++) begin
         wr0 = wr_cnt;
         rd0 = rd_cnt;
         for (int j = 0; j < vecs[i].n; j++)
            send_byte(vecs[i].b[j], !(j == 0 && vecs[i].bad_stop0));
         check($sformatf("v%0d_wr_count", i), wr_cnt - wr0, {31'h0, vecs[i].ewr});
         check($sformatf("v%0d_rd_count", i), rd_cnt - rd0, {31'h0, vecs[i].erd});
         if (vecs[i].ewr) begin
            check($sformatf("v%0d_wr_pid", i), wr_pid, vecs[i].epid);
            check($sformatf("v%0d_wr_dat", i), wr_dat, vecs[i].edat);
         end
         if (vecs[i].erd) check($sformatf("v%0d_rd_pid", i), rd_pid, vecs[i].epid);
         check($sformatf("v%0d_port_id", i), port_id, vecs[i].epid);
         check($sformatf("v%0d_out_port", i), out_port, vecs[i].edat);
         wait_rsp($sformatf("v%0d_rsp", i), vecs[i].ersp);
         check($sformatf("v%0d_busy_after", i), busy, 0);
         if (i == 0) check("ack_frame", mon_frame, {1'b1, 8'h2E, 1'b0});
      end

      // Short low pulse must be rejected as a glitch
      rx = 1'b0;
      repeat (100) @(negedge clk);
      rx = 1'b1;
      repeat (600) @(negedge clk);
      check("glitch_busy", busy, 0);
      check("glitch_no_tx", tx_q.size(), 0);

      wr0 = wr_cnt;
      rd0 = rd_cnt;
      send_byte(8'h57, 1'b1);
      send_byte(8'h20, 1'b1);
      check("wait_busy", busy, 1);
`ifdef UART_PORT_BRIDGE_TIMEOUT_EN
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("to_busy_fell", busy, 0);
      check("to_latency_ok", (n > 500 && n < 800), 1);
      check("to_no_rsp", tx_q.size(), 0);
      send_byte(8'h52, 1'b1);
      send_byte(8'h20, 1'b1);
      check("to_wr_count", wr_cnt - wr0, 0);
      check("to_rd_count", rd_cnt - rd0, 1);
      wait_rsp("to_rsp", 8'h11);
`else
      repeat (1500) @(negedge clk);
      check("nto_still_busy", busy, 1);
      send_byte(8'h77, 1'b1);
      check("nto_wr_count", wr_cnt - wr0, 1);
      check("nto_wr_pid", wr_pid, 8'h20);
      check("nto_wr_dat", wr_dat, 8'h77);
      wait_rsp("nto_rsp", 8'h2E);
`endif
      check("no_overlap", both_cnt, 0);

      // Asynchronous reset while a response is mid-frame
      send_byte(8'h41, 1'b1);
      n = 0;
      while (tx !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_tx_started", tx, 0);
      repeat (1000) @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_tx", tx, 1);
      check("arst_busy", busy, 0);
      check("arst_port_id", port_id, 0);
      check("arst_out_port", out_port, 0);
      check("arst_strobes", {write_strobe, read_strobe}, 0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_tx", tx, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_port_bridge.md
Name: uart_port_bridge

Overview:
- Serial-to-port-bus initiator: the host end of the UART link, driving the KCPSM3-style port bus (port_id/out_port/in_port/strobes) from commands received on rx.
- Lets a PC poke and peek port-mapped peripherals without a processor.
- Read results and status go back on tx.
- Contains its own 16x baud generator, 8N1 receiver, 8N1 transmitter and command FSM.

Parameters:
- BAUD_DIV, 26, clk cycles per 16x-baud tick (48 MHz / (115200*16)).
- TIMEOUT_TICKS, 4096, 16x ticks allowed between bytes of one command (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx  in  1  serial input, 8N1, idle high
- tx  out  1  serial output, 8N1, idle high
- port_id  out  8  port address
- out_port  out  8  write data
- write_strobe  out  1  one-cycle write qualifier
- read_strobe  out  1  one-cycle read qualifier
- in_port  in  8  read data, registered by the responder (valid one cycle after port_id)
- busy  out  1  high whenever the FSM is outside IDLE

Behaviour:
- Reset values: tx=1, port_id=0, out_port=0, write_strobe=0, read_strobe=0, busy=0, baud counter=0, FSM=IDLE.
- Baud: counter 0..BAUD_DIV-1; tick pulses for one cycle when the counter wraps.
- rx path:
  - Two-flop synchroniser.
  - Start is a falling edge seen on a tick.
  - Start is re-checked low at tick 8; if high, the start is discarded as a glitch.
  - Data bits are sampled every 16 ticks thereafter, LSB first.
  - Stop bit is sampled at bit 9: if 0, framing error, byte dropped, no response; if 1, byte_valid pulses for one cycle.
- tx path:
  - One-byte holding register; load accepted only when the serialiser is idle.
  - Each bit lasts 16 ticks: start 0, 8 data bits LSB first, stop 1.
  - Back-to-back loads produce no gap beyond the stop bit.
- Command FSM:
  - IDLE: on byte 0x57 ('W') go to W_ADDR; on 0x52 ('R') go to R_ADDR; any other byte loads response 0x3F ('?') and goes to SEND.
  - W_ADDR: next byte is latched into port_id; go to W_DATA.
  - W_DATA: next byte is latched into out_port; go to W_STB.
  - W_STB: write_strobe=1 for exactly one cycle, with port_id/out_port stable that cycle; load response 0x2E ('.'); go to SEND.
  - R_ADDR: next byte is latched into port_id; go to R_WAIT.
  - R_WAIT: one cycle with port_id stable so the responder can register in_port.
  - R_STB: read_strobe=1 for one cycle; in_port is captured at the end of this cycle; the captured byte is the response; go to SEND.
  - SEND: wait for the tx serialiser to be idle, load the response, return to IDLE.
- port_id and out_port hold their last values after a transaction and are never cleared except by reset.
- Bytes arriving outside IDLE/W_ADDR/W_DATA/R_ADDR are discarded; the rx deserialiser keeps running so framing stays aligned.
- Strobes never assert simultaneously, and never while rst is low.
- Asynchronous reset mid-transaction:
  - All outputs return to reset values immediately.
  - A byte partially shifted out on tx is truncated; tx goes high.
  - A partial command is lost.

Optional Feature:
- Macro UART_PORT_BRIDGE_TIMEOUT_EN.
- Defined: a tick counter runs in W_ADDR/W_DATA/R_ADDR and resets on each received byte. Reaching TIMEOUT_TICKS forces IDLE with no strobe and no response. busy drops on the next cycle.
- Undefined: no counter; the FSM waits indefinitely for the remaining command bytes.

Decomposition:
- Package uart_port_bridge_pkg holds:
  - command codes CMD_WR=8'h57, CMD_RD=8'h52;
  - responses RSP_ACK=8'h2E, RSP_ERR=8'h3F;
  - the FSM state enum (IDLE, W_ADDR, W_DATA, W_STB, R_ADDR, R_WAIT, R_STB, SEND).
- One natural sub-module: bridge_serial_rx (synchroniser, 16x oversampler, framing check, byte_valid).
- tx serialiser and FSM stay in the top.

Test Plan (BAUD_DIV=26, one bit = 416 clk):
- Reset release, rx idle high -> tx stays 1; all port outputs 0; busy 0 for 20 bit times.
- Send 57 10 A5 -> exactly one write_strobe cycle with port_id=0x10, out_port=0xA5; tx then emits 0x2E, frame = 0,0,1,1,1,0,1,0,0,1.
- Send 52 01; responder registers in_port=0x3C one cycle after port_id=0x01 -> read_strobe pulses once; tx emits 0x3C.
- Send 0x00 -> tx emits 0x3F; no strobes.
- Send 0x57 with stop bit forced 0, then 52 00 with in_port=0x99 -> framed byte ignored; only the read executes; tx emits 0x99.
- With UART_PORT_BRIDGE_TIMEOUT_EN: send 57 20, idle 4096 ticks, then send 52 20 (in_port=0x11) -> no write_strobe ever; busy falls after the timeout; response 0x11.
